// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the store buffer: entry layout and byte-lane merge helper.
package mem_store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] pa;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
        logic                 cached;
    } sb_entry_t;

    function automatic logic [SB_DATA_W-1:0] lane_merge(
        input logic [SB_DATA_W-1:0] old_data,
        input logic [SB_DATA_W-1:0] new_data,
        input logic [SB_STRB_W-1:0] strb
    );
        logic [SB_DATA_W-1:0] r;
        r = old_data;
        for (int b = 0; b < SB_STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_data[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_store_buffer_fwd_match.sv
// Load forwarding match: word compare per entry, walked oldest to youngest
// so the youngest writer of each needed lane wins.
module sb_fwd_match
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [PW-1:0]        head,
    input  logic [CW-1:0]        count,
    input  logic [SB_ADDR_W-1:0] ld_pa,
    input  logic [SB_STRB_W-1:0] ld_strb,
    output logic [SB_STRB_W-1:0] hit_strb,
    output logic [SB_DATA_W-1:0] data
);

    localparam int OFF = $clog2(SB_STRB_W);
    localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          unused_x;

    always_comb begin
        hit_strb = '0;
        data     = '0;
        sum      = '0;
        idx      = '0;
        unused_x = ^ld_pa[OFF-1:0];
        for (int k = 0; k < DEPTH; k++) begin
            sum = {1'b0, head} + (PW + 1)'(k);
            if (sum >= DEPTH_P) sum = sum - DEPTH_P;
            idx = sum[PW-1:0];
            unused_x = unused_x ^ entries[idx].cached
                     ^ (^entries[idx].pa[OFF-1:0]);
            if (CW'(k) < count && entries[idx].valid &&
                entries[idx].pa[SB_ADDR_W-1:OFF] == ld_pa[SB_ADDR_W-1:OFF]) begin
                for (int b = 0; b < SB_STRB_W; b++) begin
                    if (entries[idx].strb[b] && ld_strb[b]) begin
                        hit_strb[b]     = 1'b1;
                        data[8*b +: 8]  = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Committed-store buffer: in-order drain to dcache, youngest-entry merging
// and same-cycle load forwarding from registered entries.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = SB_ADDR_W,
    parameter int DATA_W   = SB_DATA_W,
    parameter int STRB_W   = DATA_W / 8,
    parameter bit MERGE_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_rdy,
    input  logic [ADDR_W-1:0]          enq_pa,
    input  logic [DATA_W-1:0]          enq_data,
    input  logic [STRB_W-1:0]          enq_strb,
    input  logic                       enq_cached,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_pa,
    input  logic [STRB_W-1:0]          ld_strb,
    input  logic                       ld_cached,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_stall,
    output logic                       dc_valid,
    input  logic                       dc_busy,
    output logic [ADDR_W-1:0]          dc_pa,
    output logic [DATA_W-1:0]          dc_data,
    output logic [STRB_W-1:0]          dc_strb,
    output logic                       dc_cached,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OFF = $clog2(STRB_W);

    sb_entry_t     ent [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] young;
    logic          merge_ok;
    logic          do_enq;
    logic          do_push;
    logic          do_merge;
    logic          do_deq;
    logic [STRB_W-1:0] hit_strb;
    logic [DATA_W-1:0] fwd_data;
    logic              mmio_block;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign young = (tail == '0) ? PW'(DEPTH - 1) : tail - 1'b1;

    // The head is never a merge target, so an offered head stays stable.
    assign merge_ok = MERGE_EN && count != '0 && young != head &&
                      enq_cached && ent[young].valid && ent[young].cached &&
                      ent[young].pa[ADDR_W-1:OFF] == enq_pa[ADDR_W-1:OFF];

    assign enq_rdy  = (count != CW'(DEPTH)) | merge_ok;
    assign do_enq   = enq_valid & enq_rdy;
    assign do_merge = do_enq & merge_ok;
    assign do_push  = do_enq & ~merge_ok;
    assign do_deq   = dc_valid & ~dc_busy;

    assign dc_valid  = count != '0;
    assign empty     = count == '0;
    assign dc_pa     = ent[head].pa;
    assign dc_data   = ent[head].data;
    assign dc_strb   = ent[head].strb;
    assign dc_cached = ent[head].cached;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            if (do_deq) begin
                ent[head].valid <= 1'b0;
                head            <= nxt(head);
            end
            if (do_push) begin
                ent[tail] <= '{valid: 1'b1, pa: enq_pa, data: enq_data,
                               strb: enq_strb, cached: enq_cached};
                tail      <= nxt(tail);
            end
            if (do_merge) begin
                ent[young].data <= lane_merge(ent[young].data, enq_data, enq_strb);
                ent[young].strb <= ent[young].strb | enq_strb;
            end
            unique case ({do_push, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fwd (
        .entries  (ent),
        .head     (head),
        .count    (count),
        .ld_pa    (ld_pa),
        .ld_strb  (ld_strb),
        .hit_strb (hit_strb),
        .data     (fwd_data)
    );

    // Uncached loads wait for the buffer to drain to keep MMIO ordering.
    assign mmio_block = ~ld_cached & (count != '0);
    assign ld_data    = fwd_data;
    assign ld_hit     = ld_valid & ~mmio_block & (hit_strb != '0) &
                        (hit_strb == ld_strb);
    assign ld_stall   = ld_valid & (mmio_block |
                        ((hit_strb != '0) & (hit_strb != ld_strb)));

endmodule
